// File: rtl/rvfi_pkg.sv
// Shared definitions for the RVFI shadow reorder buffer: per-entry record,
// default depth and the halt instruction encoding.
package rvfi_pkg;

    localparam int unsigned ROB_DEPTH_DEFAULT = 16;
    localparam logic [31:0] HALT_INST = 32'h0000006f;

    typedef struct packed {
        logic        alloc;
        logic        wb_done;
        logic [31:0] inst;
        logic [31:0] pc;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [4:0]  rd_addr;
        logic [31:0] rs1_rdata;
        logic [31:0] rs2_rdata;
        logic [31:0] rd_wdata;
        logic [31:0] pc_wdata;
        logic [31:0] mem_addr;
        logic [31:0] mem_rdata;
        logic [31:0] mem_wdata;
        logic [3:0]  mem_rmask;
        logic [3:0]  mem_wmask;
    } rvfi_entry_t;

endpackage

// File: rtl/rvfi_shadow_rob.sv
// Shadow reorder buffer that collects dispatch, writeback and memory records
// per entry and emits one RVFI monitor packet per in-order commit.
// Optional protocol checking is enabled by defining RVFI_SHADOW_CHECK_EN.
module rvfi_shadow_rob
    import rvfi_pkg::*;
#(
    parameter int unsigned ROB_DEPTH = ROB_DEPTH_DEFAULT,
    parameter int unsigned IDX_W     = $clog2(ROB_DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             disp_valid,
    input  logic [IDX_W-1:0] disp_idx,
    input  logic [31:0]      disp_inst,
    input  logic [31:0]      disp_pc,
    input  logic [4:0]       disp_rs1_addr,
    input  logic [4:0]       disp_rs2_addr,
    input  logic [4:0]       disp_rd_addr,
    input  logic             wb_valid,
    input  logic [IDX_W-1:0] wb_idx,
    input  logic [31:0]      wb_rs1_rdata,
    input  logic [31:0]      wb_rs2_rdata,
    input  logic [31:0]      wb_rd_wdata,
    input  logic [31:0]      wb_pc_wdata,
    input  logic             mem_valid,
    input  logic [IDX_W-1:0] mem_idx,
    input  logic [31:0]      mem_addr,
    input  logic [31:0]      mem_rdata,
    input  logic [31:0]      mem_wdata,
    input  logic [3:0]       mem_rmask,
    input  logic [3:0]       mem_wmask,
    input  logic             commit_valid,
    input  logic [IDX_W-1:0] commit_idx,
    input  logic             flush,
    output logic             mon_valid,
    output logic [63:0]      mon_order,
    output logic [31:0]      mon_inst,
    output logic [31:0]      mon_pc_rdata,
    output logic [31:0]      mon_pc_wdata,
    output logic [31:0]      mon_rs1_rdata,
    output logic [31:0]      mon_rs2_rdata,
    output logic [31:0]      mon_rd_wdata,
    output logic [31:0]      mon_mem_addr,
    output logic [31:0]      mon_mem_rdata,
    output logic [31:0]      mon_mem_wdata,
    output logic [4:0]       mon_rs1_addr,
    output logic [4:0]       mon_rs2_addr,
    output logic [4:0]       mon_rd_addr,
    output logic [3:0]       mon_mem_rmask,
    output logic [3:0]       mon_mem_wmask,
    output logic             mon_halt,
    output logic             mon_error
);

    rvfi_entry_t rob [ROB_DEPTH];
    rvfi_entry_t pkt;
    rvfi_entry_t disp_entry;
    logic [63:0] order_cnt;
    logic        wb_hits_commit;
    logic        mem_hits_commit;

    assign wb_hits_commit  = wb_valid  && (wb_idx  == commit_idx);
    assign mem_hits_commit = mem_valid && (mem_idx == commit_idx);

    // Commit view of the entry with same-cycle writeback/memory data bypassed in
    always_comb begin
        pkt = rob[commit_idx];
        if (wb_hits_commit) begin
            pkt.rs1_rdata = wb_rs1_rdata;
            pkt.rs2_rdata = wb_rs2_rdata;
            pkt.rd_wdata  = wb_rd_wdata;
            pkt.pc_wdata  = wb_pc_wdata;
            pkt.wb_done   = 1'b1;
        end
        if (mem_hits_commit) begin
            pkt.mem_addr  = mem_addr;
            pkt.mem_rdata = mem_rdata;
            pkt.mem_wdata = mem_wdata;
            pkt.mem_rmask = mem_rmask;
            pkt.mem_wmask = mem_wmask;
        end
    end

    // Fresh entry image written at dispatch: result and memory fields start cleared
    always_comb begin
        disp_entry          = '0;
        disp_entry.alloc    = 1'b1;
        disp_entry.inst     = disp_inst;
        disp_entry.pc       = disp_pc;
        disp_entry.rs1_addr = disp_rs1_addr;
        disp_entry.rs2_addr = disp_rs2_addr;
        disp_entry.rd_addr  = disp_rd_addr;
    end

    // Entry storage; later statements take priority, so dispatch overrides
    // flush/commit deallocation and any same-index writeback or memory record
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < ROB_DEPTH; i++) rob[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < ROB_DEPTH; i++) begin
                if (flush || (commit_valid && commit_idx == IDX_W'(i))) rob[i].alloc <= 1'b0;
                if (wb_valid && wb_idx == IDX_W'(i) && rob[i].alloc) begin
                    rob[i].rs1_rdata <= wb_rs1_rdata;
                    rob[i].rs2_rdata <= wb_rs2_rdata;
                    rob[i].rd_wdata  <= wb_rd_wdata;
                    rob[i].pc_wdata  <= wb_pc_wdata;
                    rob[i].wb_done   <= 1'b1;
                end
                if (mem_valid && mem_idx == IDX_W'(i) && rob[i].alloc) begin
                    rob[i].mem_addr  <= mem_addr;
                    rob[i].mem_rdata <= mem_rdata;
                    rob[i].mem_wdata <= mem_wdata;
                    rob[i].mem_rmask <= mem_rmask;
                    rob[i].mem_wmask <= mem_wmask;
                end
                if (disp_valid && disp_idx == IDX_W'(i)) rob[i] <= disp_entry;
            end
        end
    end

    // Registered monitor packet, order counter and sticky halt
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mon_valid     <= 1'b0;
            mon_order     <= '0;
            order_cnt     <= '0;
            mon_inst      <= '0;
            mon_pc_rdata  <= '0;
            mon_pc_wdata  <= '0;
            mon_rs1_rdata <= '0;
            mon_rs2_rdata <= '0;
            mon_rd_wdata  <= '0;
            mon_mem_addr  <= '0;
            mon_mem_rdata <= '0;
            mon_mem_wdata <= '0;
            mon_rs1_addr  <= '0;
            mon_rs2_addr  <= '0;
            mon_rd_addr   <= '0;
            mon_mem_rmask <= '0;
            mon_mem_wmask <= '0;
            mon_halt      <= 1'b0;
        end else begin
            mon_valid <= commit_valid;
            if (commit_valid) begin
                mon_order     <= order_cnt;
                order_cnt     <= order_cnt + 64'd1;
                mon_inst      <= pkt.inst;
                mon_pc_rdata  <= pkt.pc;
                mon_pc_wdata  <= pkt.pc_wdata;
                mon_rs1_rdata <= pkt.rs1_rdata;
                mon_rs2_rdata <= pkt.rs2_rdata;
                mon_rd_wdata  <= (pkt.rd_addr == 5'd0) ? '0 : pkt.rd_wdata;
                mon_mem_addr  <= pkt.mem_addr;
                mon_mem_rdata <= pkt.mem_rdata;
                mon_mem_wdata <= pkt.mem_wdata;
                mon_rs1_addr  <= pkt.rs1_addr;
                mon_rs2_addr  <= pkt.rs2_addr;
                mon_rd_addr   <= pkt.rd_addr;
                mon_mem_rmask <= pkt.mem_rmask;
                mon_mem_wmask <= pkt.mem_wmask;
                if (pkt.inst == HALT_INST) mon_halt <= 1'b1;
            end
        end
    end

`ifdef RVFI_SHADOW_CHECK_EN
    logic commit_bad;
    logic disp_bad;

    // A dispatch that coincides with a flush lands on a cleared buffer, so it is legal
    always_comb begin
        commit_bad = commit_valid && (!pkt.alloc || !pkt.wb_done);
        disp_bad   = disp_valid && rob[disp_idx].alloc && !flush;
    end

    // Sticky protocol error flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                       mon_error <= 1'b0;
        else if (commit_bad || disp_bad) mon_error <= 1'b1;
    end
`else
    assign mon_error = 1'b0;
`endif

endmodule

// File: doc/rvfi_shadow_rob.md
RVFI_SHADOW_ROB -- requirements
Module: rvfi_shadow_rob

Interface
REQ-001 Parameter ROB_DEPTH, default 16, number of shadow entries; power of two, minimum 4.
REQ-002 Parameter IDX_W, default $clog2(ROB_DEPTH), entry index width.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 disp_valid / disp_idx  in  1 / IDX_W  allocate entry at dispatch.
REQ-006 disp_inst, disp_pc  in  32 each  instruction word and its PC.
REQ-007 disp_rs1_addr, disp_rs2_addr, disp_rd_addr  in  5 each  architectural register numbers.
REQ-008 wb_valid / wb_idx  in  1 / IDX_W  result writeback for entry.
REQ-009 wb_rs1_rdata, wb_rs2_rdata, wb_rd_wdata, wb_pc_wdata  in  32 each  operand values, result, next PC.
REQ-010 mem_valid / mem_idx  in  1 / IDX_W  memory-access record for entry.
REQ-011 mem_addr, mem_rdata, mem_wdata  in  32 each; mem_rmask, mem_wmask  in  4 each.
REQ-012 commit_valid / commit_idx  in  1 / IDX_W  in-order retirement of entry.
REQ-013 flush  in  1  squash all uncommitted entries.
REQ-014 mon_valid  out  1; mon_order  out  64; mon_inst, mon_pc_rdata, mon_pc_wdata, mon_rs1_rdata, mon_rs2_rdata, mon_rd_wdata, mon_mem_addr, mon_mem_rdata, mon_mem_wdata  out  32 each; mon_rs1_addr, mon_rs2_addr, mon_rd_addr  out  5 each; mon_mem_rmask, mon_mem_wmask  out  4 each -- drive the single-channel monitor interface.
REQ-015 mon_halt  out  1, sticky halt; mon_error  out  1, sticky protocol error.

Function
REQ-016 Dispatch: entry[disp_idx] is loaded with dispatch fields, marked allocated, wb-done cleared, memory fields zeroed.
REQ-017 Writeback: entry[wb_idx] captures wb fields and sets wb-done; ignored if the entry is not allocated.
REQ-018 Memory record: entry[mem_idx] captures address, masks and data; ignored if not allocated.
REQ-019 Same-index dispatch and wb/mem in one cycle: dispatch wins.
REQ-020 Commit: one cycle later, mon_valid=1 with the entry's fields, and the entry is deallocated.
REQ-021 Commit and wb/mem to the same index in one cycle: incoming wb/mem data is bypassed into the output packet.
REQ-022 mon_rd_wdata is forced to 0 when mon_rd_addr==0.
REQ-023 mon_order: 0 on the first packet, +1 per packet, 64-bit wrap; held when mon_valid=0.
REQ-024 mon_valid is 0 in every cycle without a commit; other outputs hold their last value.
REQ-025 Flush: all allocated entries are deallocated at the edge; a same-cycle commit is still emitted, and a same-cycle dispatch allocates after the clear.
REQ-026 mon_halt sets when a committed inst equals 32'h0000006f (jal x0,0) and holds until reset.
REQ-027 Latency: commit to mon_valid is exactly 1 cycle; throughput is 1 packet per cycle.

Reset
REQ-028 While rst=0: all entries deallocated; mon_valid=0; mon_order=0; all mon_* data outputs=0; mon_halt=0; mon_error=0.
REQ-029 Reset asserted mid-operation discards in-flight entries; the first packet after release has order 0.

Configuration
REQ-030 With RVFI_SHADOW_CHECK_EN defined, mon_error sets on any of: commit of an unallocated entry, commit of an entry without wb-done and without same-cycle wb, or dispatch to an allocated entry. It holds until reset; in the error cases the packet is still emitted.
REQ-031 Without RVFI_SHADOW_CHECK_EN, mon_error is constant 0 and no check logic is generated.

Structure
REQ-032 Shared package rvfi_pkg holds: rvfi_entry_t struct (all per-entry fields plus allocated/wb-done bits), ROB_DEPTH default, and constant HALT_INST=32'h0000006f.
REQ-033 Single flat module; entry storage is an array of rvfi_entry_t; no sub-module.

Verification
REQ-034 Dispatch idx 3 (inst 32'h00500093, rd 1), wb rd_wdata 5, commit 3 -> next cycle mon_valid=1, order 0, rd_addr 1, rd_wdata 5.
REQ-035 Commit idx 2 with same-cycle wb rd_wdata 32'hDEAD -> packet rd_wdata 32'hDEAD; mon_error=0.
REQ-036 Write to rd 0 with wb_rd_wdata 7 -> mon_rd_wdata=0.
REQ-037 Dispatch idx 0..3, flush, then commit idx 1 -> mon_error=1 (check enabled); packet emitted; order increments.
REQ-038 Commit inst 32'h0000006f -> mon_halt=1 one cycle later and stays 1; rst=0 clears it and order returns to 0.
